c157x_gcr_head: RTL
===================

# c157x_gcr_head

Upstream bit-cell stage for the 157x 64H156 signal processor: it emulates disk rotation and the read/write head over a GCR track image held in track RAM. It produces the bit-cell strobe `hclk` and read bit `hf` consumed by the H156. In write mode it samples the H156 `ht` output, assembles bytes and writes them back into track RAM at the current rotational position. It sits between the track-buffer RAM and the H156 instance inside the drive core.

## Interface
- No parameters.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ce16` in 1: one-`clk` strobe at 16 MHz drive rate; all timing counts `ce16` strobes.
- `enable` in 1: motor on and disk present; low freezes rotation.
- `speed` in 2: density zone; 0 is slowest, 3 is fastest.
- `mode` in 1: 1 = read, 0 = write (same sense as the H156 `mode`).
- `wp` in 1: write protect; 1 suppresses all RAM writes.
- `track_len` in 13: bytes on the current track, 1..8191; 0 is treated as 1.
- `ht` in 1: write bit from the H156.
- `hclk` out 1: one-`clk` bit-cell strobe.
- `hf` out 1: current read bit.
- `index` out 1: one-`clk` pulse when the byte position wraps to 0.
- `ram_addr` out 13: track RAM byte address.
- `ram_din` in 8: track RAM read data, valid 1 `clk` after `ram_addr`.
- `ram_dout` out 8: write data.
- `ram_we` out 1: one-`clk` write strobe.

## Operation
- **Bit-cell counter** (8 bit, down-counter).
  - Decrements on `ce16` while `enable` is high.
  - On a `ce16` strobe with counter == 0: assert `hclk` for that `clk` and reload with 4*(16-`speed`)-1.
  - Cell length is 64/60/56/52 strobes for zones 0/1/2/3.
  - `speed` is sampled only at reload; a change mid-cell never truncates the current cell.
- **Bit index** `bit_idx` (3 bit): increments on each `hclk` and wraps 7→0. The step 7→0 is the byte boundary.
- **Read path.**
  - `hf` = `sr[7]`.
  - On `hclk` with `bit_idx` != 7: `sr` shifts left, filling with 0.
  - On `hclk` with `bit_idx` == 7: `sr` loads from the prefetch register `pf`.
  - Bit order is MSB first.
- **Prefetch.**
  - The `clk` after a byte boundary, `ram_addr` = next position.
  - The following `clk`, `pf` captures `ram_din`.
- **Byte position** `pos` (13 bit).
  - Advances at each byte boundary.
  - If `pos` >= `track_len`-1, it wraps to 0 and `index` pulses in the same `clk` as that `hclk`.
  - If `track_len` shrinks below `pos`, the next advance wraps to 0.
- **Write path.**
  - `mode` is latched into `bmode` at each byte boundary and governs the whole following byte.
  - On each `hclk`, `wsr` = {`wsr`[6:0], `ht`}.
  - At a byte boundary with `bmode` == 0 and `wp` == 0, the completed byte is written: `ram_dout` = {`wsr`[6:0], `ht`} at the old `pos`.
  - The write is issued the `clk` after the boundary. It takes priority over prefetch; the prefetch address follows one `clk` later.
  - No read/write collision is possible: a byte lasts at least 416 strobes.
- **`enable` low.**
  - Bit-cell counter, `bit_idx`, `pos`, `sr` and `pf` hold their values; no `hclk`, no RAM activity.
  - On re-enable, counting resumes from the held counter value.
- **Reset** (`reset_n` == 0 at a `clk` edge).
  - Outputs: `hclk` 0, `hf` 0, `index` 0, `ram_we` 0, `ram_addr` 0, `ram_dout` 0.
  - Internals: counter 63, `bit_idx` 0, `pos` 0, `sr`/`pf`/`wsr` 0, `bmode` 1.
  - A prefetch of address 0 is issued on the first `clk` after release.
  - Reset mid-write aborts any pending `ram_we`.

## Timing
- `hclk`: exactly one `clk` wide, coincident with a `ce16` strobe.
- `hf`: valid throughout the cycle `hclk` is high; changes only on the `clk` after `hclk`.
- First `hclk` after reset release with `enable` = 1: the 64th `ce16` strobe.
- Prefetch latency: `ram_addr` at boundary+1 `clk`, `pf` loaded at boundary+2; it must be ready long before the next boundary.
- Write latency: `ram_we` high for 1 `clk` at boundary+1 (boundary+1 is the prefetch slot); prefetch then moves to +2 and the `pf` capture to +3.
- `index` and the boundary `hclk` are in the same `clk`.

## Test plan
- **Zone timing:** `ce16` every `clk`, `speed` = 0 then 3 → `hclk` spacing 64 then 52 `clk`; the speed change mid-cell takes effect only after the next `hclk`.
- **Read stream:** RAM holds 0xFF,0x52,0xA5, `track_len` = 3 → `hf` sampled at `hclk` yields 11111111 01010010 10100101; `index` pulses once per 24 `hclk`.
- **Wrap:** `track_len` = 3, `pos` 2 → boundary gives `pos` 0 with one `index`; `track_len` changed to 1 while `pos` = 2 → next boundary gives `pos` 0.
- **Write-back:** `mode` = 0, `wp` = 0, `ht` driven 1,0,1,1,0,1,0,1 over one byte → `ram_we` once, `ram_dout` = 0xB5 at the old `pos`; with `wp` = 1 → `ram_we` never asserts.
- **`enable` hold:** drop `enable` mid-cell for 100 strobes → no `hclk`, `pos` frozen; the remaining cell length is preserved on resume.
- **Reset mid-byte:** pull `reset_n` low 1 `clk` during a write byte → no `ram_we`; `pos` 0, `hf` 0, first `hclk` 64 strobes after release.

Source files
------------

// File: rtl/c157x_gcr_head.sv
// Rotation and read/write head model feeding the 64H156: paces bit cells per density
// zone, streams the GCR track image out MSB first and assembles written bytes back into track RAM.
module c157x_gcr_head (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce16,
  input  logic        enable,
  input  logic [1:0]  speed,
  input  logic        mode,
  input  logic        wp,
  input  logic [12:0] track_len,
  input  logic        ht,
  output logic        hclk,
  output logic        hf,
  output logic        index,
  output logic [12:0] ram_addr,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic        ram_we
);

  // RAM sequencer: optional write slot, then prefetch address, wait, capture.
  typedef enum logic [1:0] {
    RS_IDLE    = 2'd0,
    RS_PF_ADDR = 2'd1,
    RS_PF_WAIT = 2'd2,
    RS_PF_CAP  = 2'd3
  } ram_state_e;

  ram_state_e  ram_state_q, ram_state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [12:0] pos_q, pos_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  pf_q, pf_d;
  logic [7:0]  wsr_q, wsr_d;
  logic        bmode_q, bmode_d;
  logic [12:0] ram_addr_q, ram_addr_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_we_q, ram_we_d;

  logic        strobe;
  logic        hclk_w;
  logic        boundary;
  logic [12:0] len_m1;
  logic        wrap;
  logic [12:0] pos_next;
  logic [7:0]  wr_byte;
  logic        do_write;
  logic [7:0]  reload;

  always_comb begin
    strobe   = ce16 & enable;
    hclk_w   = reset_n & strobe & (cnt_q == 8'd0);
    boundary = hclk_w & (bit_idx_q == 3'd7);
    // A zero track length behaves like a one-byte track.
    len_m1   = (track_len == 13'd0) ? 13'd0 : (track_len - 13'd1);
    wrap     = (pos_q >= len_m1);
    pos_next = wrap ? 13'd0 : (pos_q + 13'd1);
    wr_byte  = {wsr_q[6:0], ht};
    do_write = boundary & ~bmode_q & ~wp;
    reload   = 8'd63 - {4'd0, speed, 2'b00};
  end

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    pos_d       = pos_q;
    sr_d        = sr_q;
    pf_d        = pf_q;
    wsr_d       = wsr_q;
    bmode_d     = bmode_q;
    ram_state_d = ram_state_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_we_d    = 1'b0;

    if (strobe) begin
      cnt_d = (cnt_q == 8'd0) ? reload : (cnt_q - 8'd1);
    end

    if (hclk_w) begin
      bit_idx_d = bit_idx_q + 3'd1;
      wsr_d     = wr_byte;
      sr_d      = (bit_idx_q == 3'd7) ? pf_q : {sr_q[6:0], 1'b0};
    end

    if (boundary) begin
      pos_d   = pos_next;
      bmode_d = mode;
    end

    if (boundary) begin
      if (do_write) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = pos_q;
        ram_dout_d  = wr_byte;
        ram_state_d = RS_PF_ADDR;
      end else begin
        ram_addr_d  = pos_next;
        ram_state_d = RS_PF_WAIT;
      end
    end else if (enable) begin
      case (ram_state_q)
        RS_PF_ADDR: begin
          ram_addr_d  = pos_q;
          ram_state_d = RS_PF_WAIT;
        end
        RS_PF_WAIT: ram_state_d = RS_PF_CAP;
        RS_PF_CAP: begin
          pf_d        = ram_din;
          ram_state_d = RS_IDLE;
        end
        default: ram_state_d = RS_IDLE;
      endcase
    end
  end

  // Reset leaves address 0 on the bus in the wait state, so byte 0 is fetched right after release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= 8'd63;
      bit_idx_q   <= 3'd0;
      pos_q       <= 13'd0;
      sr_q        <= 8'd0;
      pf_q        <= 8'd0;
      wsr_q       <= 8'd0;
      bmode_q     <= 1'b1;
      ram_state_q <= RS_PF_WAIT;
      ram_addr_q  <= 13'd0;
      ram_dout_q  <= 8'd0;
      ram_we_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      pos_q       <= pos_d;
      sr_q        <= sr_d;
      pf_q        <= pf_d;
      wsr_q       <= wsr_d;
      bmode_q     <= bmode_d;
      ram_state_q <= ram_state_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_we_q    <= ram_we_d;
    end
  end

  assign hclk     = hclk_w;
  assign hf       = sr_q[7];
  assign index    = boundary & wrap;
  assign ram_addr = ram_addr_q;
  assign ram_dout = ram_dout_q;
  assign ram_we   = ram_we_q;

endmodule
